// File: rtl/udl_counter_mod.sv
// Up/down/load counter with runtime modulus, step size, wrap/saturate mode and event pulse.
// Optional sticky event flag enabled by defining UDL_CNT_STICKY_EN.
module udl_counter_mod #(
  parameter int N = 4,
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         down,
  input  logic         load,
  input  logic [N-1:0] in,
  input  logic [S-1:0] step,
  input  logic [N-1:0] limit,
  input  logic         sat,
  input  logic         ovf_clr,
  output logic [N-1:0] out,
  output logic         evt,
  output logic         at_max,
  output logic         at_zero,
  output logic         ovf_sticky
);

  generate
    if (S > N) begin : g_bad_step_width
      $error("udl_counter_mod: S must not exceed N");
    end
  endgenerate

  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  logic [N:0]   s_eff;
  logic [N:0]   cur;
  logic [N:0]   lim;
  logic [N:0]   lim1;
  logic [N:0]   sum_up;
  logic [N:0]   wrap_up;
  logic [N:0]   base_dn;
  logic [N:0]   wrap_dn;
  logic [N-1:0] dif_dn;
  logic         req_up;
  logic         req_dn;
  logic [N-1:0] nxt_out;
  logic         nxt_evt;

  // All arithmetic carries one extra bit so overshoot is visible before comparison.
  always_comb begin
    s_eff   = (step == '0) ? ONE : {{(N+1-S){1'b0}}, step};
    cur     = {1'b0, out};
    lim     = {1'b0, limit};
    lim1    = lim + ONE;
    sum_up  = cur + s_eff;
    wrap_up = sum_up - lim1;
    base_dn = cur + lim1;
    wrap_dn = base_dn - s_eff;
    dif_dn  = out - s_eff[N-1:0];
    req_up  = en & up & ~down;
    req_dn  = en & down & ~up;
  end

  always_comb begin
    nxt_out = out;
    nxt_evt = 1'b0;
    if (load) begin
      nxt_out = (in > limit) ? limit : in;
    end else if (req_up || req_dn) begin
      if (out > limit) begin
        // limit was lowered beneath the held count
        nxt_out = sat ? limit : '0;
        nxt_evt = 1'b1;
      end else if (req_up) begin
        if (sum_up <= lim) begin
          nxt_out = sum_up[N-1:0];
        end else begin
          nxt_evt = 1'b1;
          if (sat)
            nxt_out = limit;
          else if (wrap_up > lim)
            nxt_out = '0;
          else
            nxt_out = wrap_up[N-1:0];
        end
      end else begin
        if (cur >= s_eff) begin
          nxt_out = dif_dn;
        end else begin
          nxt_evt = 1'b1;
          if (sat)
            nxt_out = '0;
          else if ((base_dn < s_eff) || (wrap_dn > lim))
            nxt_out = limit;
          else
            nxt_out = wrap_dn[N-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      evt <= 1'b0;
    end else begin
      out <= nxt_out;
      evt <= nxt_evt;
    end
  end

  assign at_max  = (out == limit);
  assign at_zero = (out == '0);

`ifdef UDL_CNT_STICKY_EN
  // A new event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_sticky <= 1'b0;
    else if (nxt_evt)
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_udl_counter_mod.sv
// Randomized bench for udl_counter_mod against an arithmetic model of the counting rules,
// plus directed literal checks of the reset, wrap, saturate, priority and limit-change cases.
module tb_udl_counter_mod;
  localparam int N = 4;
  localparam int S = 2;
`ifdef UDL_CNT_STICKY_EN
  localparam int STK = 1;
`else
  localparam int STK = 0;
`endif

  logic         clk = 1'b0;
  logic         rst, en, up, down, load, sat, ovf_clr;
  logic [N-1:0] in, limit;
  logic [S-1:0] step;
  logic [N-1:0] out;
  logic         evt, at_max, at_zero, ovf_sticky;

  int n_cmp = 0;
  int n_bad = 0;
  int m_out = 0;
  int m_evt = 0;
  int m_stk = 0;

  udl_counter_mod #(.N(N), .S(S)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .down(down), .load(load),
    .in(in), .step(step), .limit(limit), .sat(sat), .ovf_clr(ovf_clr),
    .out(out), .evt(evt), .at_max(at_max), .at_zero(at_zero), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on every edge from the inputs held across it, then all outputs are compared.
  task automatic tick();
    int s, lim, t, w, no, ne;
    @(posedge clk);
    s   = (int'(step) == 0) ? 1 : int'(step);
    lim = int'(limit);
    no  = m_out;
    ne  = 0;
    if (load) begin
      no = (int'(in) > lim) ? lim : int'(in);
    end else if (en && (up != down)) begin
      if (m_out > lim) begin
        no = sat ? lim : 0;
        ne = 1;
      end else if (up) begin
        t = m_out + s;
        if (t <= lim) no = t;
        else begin
          ne = 1;
          if (sat) no = lim;
          else begin
            w  = t - (lim + 1);
            no = (w > lim) ? 0 : w;
          end
        end
      end else begin
        t = m_out - s;
        if (t >= 0) no = t;
        else begin
          ne = 1;
          if (sat) no = 0;
          else begin
            w  = m_out + lim + 1 - s;
            no = (w < 0 || w > lim) ? lim : w;
          end
        end
      end
    end
    if (rst) begin
      m_out = 0; m_evt = 0; m_stk = 0;
    end else begin
      if (STK == 1) begin
        if (ne == 1) m_stk = 1;
        else if (ovf_clr) m_stk = 0;
      end
      m_out = no;
      m_evt = ne;
    end
    #1;
    chk("model_out", int'(out), m_out);
    chk("model_evt", int'(evt), m_evt);
    chk("model_at_max", int'(at_max), int'(m_out == int'(limit)));
    chk("model_at_zero", int'(at_zero), int'(m_out == 0));
    chk("model_sticky", int'(ovf_sticky), m_stk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b0; down = 1'b0; load = 1'b1; sat = 1'b0;
    ovf_clr = 1'b0; in = 4'd5; limit = 4'd9; step = 2'd1;
    #2;

    // reset overrides load
    ticks(2);
    chk("rst_out", int'(out), 0);
    chk("rst_evt", int'(evt), 0);
    chk("rst_sticky", int'(ovf_sticky), 0);
    rst = 1'b0; load = 1'b0; up = 1'b1;
    ticks(7);
    chk("count_to_7", int'(out), 7);
    rst = 1'b1;
    tick();
    chk("rst_midcount", int'(out), 0);

    // wrap up, limit 9, step 1
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      int e;
      e = (i < 9) ? i + 1 : i - 9;
      tick();
      chk("wrap_up_out", int'(out), e);
      chk("wrap_up_evt", int'(evt), int'(i == 9));
      chk("wrap_up_at_max", int'(at_max), int'(e == 9));
    end

    // saturate up from 7 with step 3
    up = 1'b0; load = 1'b1; in = 4'd7;
    tick();
    load = 1'b0; step = 2'd3; sat = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_up_out", int'(out), 9);
      chk("sat_up_evt", int'(evt), 1);
      chk("sat_up_sticky", int'(ovf_sticky), STK);
    end
    ovf_clr = 1'b1;
    tick();
    chk("sticky_set_wins", int'(ovf_sticky), STK);
    up = 1'b0;
    tick();
    chk("sticky_cleared", int'(ovf_sticky), 0);
    chk("sat_hold_evt", int'(evt), 0);

    // wrap down, step 2: 1 -> 9 (modulo 10), then 8 -> 6
    ovf_clr = 1'b0; sat = 1'b0; step = 2'd2; load = 1'b1; in = 4'd1;
    tick();
    load = 1'b0; down = 1'b1;
    tick();
    chk("wrap_dn_out", int'(out), 9);
    chk("wrap_dn_evt", int'(evt), 1);
    down = 1'b0; load = 1'b1; in = 4'd8;
    tick();
    load = 1'b0; down = 1'b1;
    tick();
    chk("dn_8_6_out", int'(out), 6);
    chk("dn_8_6_evt", int'(evt), 0);
    down = 1'b0; load = 1'b1; in = 4'd0;
    tick();
    load = 1'b0; step = 2'd0; down = 1'b1;
    tick();
    chk("step0_wrap_dn", int'(out), 9);
    chk("at_max_9", int'(at_max), 1);

    // priority
    down = 1'b0; step = 2'd1; load = 1'b1; in = 4'd12; up = 1'b1;
    tick();
    chk("clamp_load_out", int'(out), 9);
    chk("clamp_load_evt", int'(evt), 0);
    load = 1'b0; down = 1'b1;
    tick();
    chk("updown_hold", int'(out), 9);
    down = 1'b0; en = 1'b0;
    tick();
    chk("en0_hold", int'(out), 9);
    load = 1'b1; in = 4'd3;
    tick();
    chk("en0_load", int'(out), 3);

    // limit lowered under the count
    en = 1'b1; up = 1'b0; limit = 4'd15; in = 4'd12;
    tick();
    load = 1'b0; limit = 4'd5;
    tick();
    chk("oor_hold", int'(out), 12);
    up = 1'b1;
    tick();
    chk("oor_wrap_out", int'(out), 0);
    chk("oor_wrap_evt", int'(evt), 1);
    up = 1'b0; load = 1'b1; limit = 4'd15;
    tick();
    load = 1'b0; limit = 4'd5; sat = 1'b1; up = 1'b1;
    tick();
    chk("oor_sat_out", int'(out), 5);
    chk("oor_sat_evt", int'(evt), 1);

    // limit 0
    sat = 1'b0; limit = 4'd0;
    tick();
    chk("lim0_up_out", int'(out), 0);
    chk("lim0_up_evt", int'(evt), 1);
    up = 1'b0; down = 1'b1; step = 2'd3;
    tick();
    chk("lim0_dn_out", int'(out), 0);
    chk("lim0_dn_evt", int'(evt), 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 149) == 0);
      load    = ($urandom_range(0, 9) == 0);
      en      = ($urandom_range(0, 4) != 0);
      up      = 1'($urandom_range(0, 1));
      down    = 1'($urandom_range(0, 1));
      in      = 4'($urandom_range(0, 15));
      step    = 2'($urandom_range(0, 3));
      ovf_clr = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) limit = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) sat = 1'($urandom_range(0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
